// File: rtl/test_vec_pkg.sv
// Shared types and constants for the vector-issuing binary-op checker.
// Holds the operation and state enums and the maximal-length Galois LFSR
// feedback masks for every supported width (2..32).
package test_vec_pkg;

    // Operation the checker computes its expected result with
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5
    } op_e;

    // Checker run state, also exported on the debug port
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // Right-shifting Galois feedback mask: bit (n-1) set for each polynomial
    // tap n. Each mask gives a maximal-length (2^w - 1) sequence.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_3802;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_B400;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0007_2000;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/test_vec_lfsr.sv
// Free-running-on-demand Galois LFSR. 'value' is the current state; it steps
// once on every clock where 'advance' is high. A seed that truncates to zero
// is replaced by 1 so the register can never lock up.
module test_vec_lfsr
    import test_vec_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    localparam logic [31:0]      TAPS_FULL  = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS       = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_TRUNC = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_INIT  =
        (SEED_TRUNC == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED_TRUNC;

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;

    // One Galois step: shift right, fold the feedback mask in when a 1 falls out
    always_comb begin
        w_next = r_state >> 1;
        if (r_state[0]) begin
            w_next = w_next ^ TAPS;
        end
    end

    // State register: reload seed on reset, step only when asked
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= SEED_INIT;
        end else if (advance) begin
            r_state <= w_next;
        end
    end

    assign value = r_state;

endmodule

// File: rtl/test_vec_binop.sv
// Self-contained test-vector source and result checker for a binary-op DUT.
// Issues NUM_VECTORS operand pairs (two fixed corner vectors, then LFSR
// values), computes OP(a,b) mod 2^WIDTH, delays it LATENCY cycles alongside
// a valid bit, and compares it against dut_y. Mismatches set a sticky fail
// flag and bump a saturating counter; finish rises once the last compare
// has been made.
//
// Timing: vector k sits on dut_a/dut_b during cycle k (cycle 0 = first cycle
// with reset low); its result is compared in cycle k+LATENCY. There is no
// handshake: the DUT is assumed to produce one result per cycle at a fixed
// latency, and dut_y is ignored whenever no valid expectation is due.
module test_vec_binop
    import test_vec_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter op_e         OP          = OP_ADD,
    parameter int          LATENCY     = 0,
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] SEED_A      = 32'h0000_005A,
    parameter logic [31:0] SEED_B      = 32'h0000_003C
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_y,
    output logic             fail,
    output logic             finish,
    output logic [15:0]      err_count,
    output logic [1:0]       dbg_state
);

    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_DRAIN = 4'(LATENCY - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [15:0]      r_idx;
    logic [15:0]      w_idx_next;
    logic [3:0]       r_drain;
    logic [3:0]       w_drain_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic             w_advance;
    logic [WIDTH-1:0] w_lfsr_a;
    logic [WIDTH-1:0] w_lfsr_b;

    logic             w_cur_vld;
    logic [WIDTH-1:0] w_cur_exp;
    logic             w_chk_vld;
    logic [WIDTH-1:0] w_chk_exp;
    logic             w_mismatch;
    logic             r_fail;
    logic [15:0]      r_err;

    test_vec_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED_A)
    ) u_lfsr_a (
        .clock   (clock),
        .reset   (reset),
        .advance (w_advance),
        .value   (w_lfsr_a)
    );

    test_vec_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED_B)
    ) u_lfsr_b (
        .clock   (clock),
        .reset   (reset),
        .advance (w_advance),
        .value   (w_lfsr_b)
    );

    // Next state, next vector index and next operand pair. Operands are
    // zero outside RUN; the LFSRs only step when they supply a vector.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_drain_next = r_drain;
        w_a_next     = '0;
        w_b_next     = '0;
        w_advance    = 1'b0;
        w_cur_vld    = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_cur_vld = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_drain_next = '0;
                    w_state_next = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    w_idx_next = r_idx + 16'd1;
                    if (r_idx == 16'd0) begin
                        w_a_next = '1;
                        w_b_next = {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        w_a_next  = w_lfsr_a;
                        w_b_next  = w_lfsr_b;
                        w_advance = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                w_drain_next = r_drain + 4'd1;
                if (r_drain == LAST_DRAIN) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // State, index and operand registers; reset presents vector 0 (0,0)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            r_drain <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_drain <= w_drain_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
        end
    end

    // Expected result of the vector currently on the operand outputs
    always_comb begin
        w_cur_exp = '0;
        case (OP)
            OP_ADD:  w_cur_exp = r_a + r_b;
            OP_SUB:  w_cur_exp = r_a - r_b;
            OP_MUL:  w_cur_exp = r_a * r_b;
            OP_AND:  w_cur_exp = r_a & r_b;
            OP_OR:   w_cur_exp = r_a | r_b;
            OP_XOR:  w_cur_exp = r_a ^ r_b;
            default: w_cur_exp = '0;
        endcase
    end

    generate
        if (LATENCY == 0) begin : g_no_pipe
            assign w_chk_vld = w_cur_vld;
            assign w_chk_exp = w_cur_exp;
        end else begin : g_pipe
            logic [LATENCY-1:0] r_vld_pipe;
            logic [WIDTH-1:0]   r_exp_pipe [LATENCY];

            // Delay line matching the DUT latency; only the valid bits need clearing
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_vld_pipe <= '0;
                end else begin
                    r_vld_pipe[0] <= w_cur_vld;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_vld_pipe[i] <= r_vld_pipe[i-1];
                    end
                end
                r_exp_pipe[0] <= w_cur_exp;
                for (int i = 1; i < LATENCY; i++) begin
                    r_exp_pipe[i] <= r_exp_pipe[i-1];
                end
            end

            assign w_chk_vld = r_vld_pipe[LATENCY-1];
            assign w_chk_exp = r_exp_pipe[LATENCY-1];
        end
    endgenerate

    assign w_mismatch = w_chk_vld && (dut_y != w_chk_exp);

    // Sticky fail flag and saturating mismatch counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fail <= 1'b0;
            r_err  <= '0;
        end else if (w_mismatch) begin
            r_fail <= 1'b1;
            if (r_err != 16'hFFFF) begin
                r_err <= r_err + 16'd1;
            end
        end
    end

    assign dut_a     = r_a;
    assign dut_b     = r_b;
    assign fail      = r_fail;
    assign err_count = r_err;
    assign finish    = (r_state == ST_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_test_vec_binop.sv
// Bench for test_vec_binop. Several checker instances run side by side on
// one clock, each paired with a small stand-in DUT:
//   u_add   : 8-bit ADD, LATENCY 0, correct combinational adder
//   u_stuck : 8-bit ADD, LATENCY 0, result stuck at zero
//   u_l2    : 8-bit ADD, LATENCY 2, two-stage registered adder
//   u_l1    : 8-bit ADD, LATENCY 1, same two-stage adder (latency wrong)
//   u_sub   : 8-bit SUB, LATENCY 0, result driven from the vector table
//   u_long  : 16-bit MUL, 65535 vectors, result always off by one
// The vector table below holds hand-computed operands (LFSR 0xB8, seeds
// 0x5A / 0x3C) and their 8-bit sums and differences.
module tb_test_vec_binop;
    import test_vec_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset      = 1'b1;
    logic reset_long = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y_add;
        logic [7:0] y_sub;
    } vec_t;

    vec_t tbl [16];

    logic [7:0]  add_a, add_b, add_y;
    logic        add_fail, add_finish;
    logic [15:0] add_err;
    logic [1:0]  add_st;

    logic [7:0]  stuck_a, stuck_b;
    logic        stuck_fail, stuck_finish;
    logic [15:0] stuck_err;
    logic [1:0]  stuck_st;

    logic [7:0]  l2_a, l2_b, l2_p1, l2_p2;
    logic        l2_fail, l2_finish;
    logic [15:0] l2_err;
    logic [1:0]  l2_st;

    logic [7:0]  l1_a, l1_b, l1_p1, l1_p2;
    logic        l1_fail, l1_finish;
    logic [15:0] l1_err;
    logic [1:0]  l1_st;

    logic [7:0]  sub_a, sub_b;
    logic [7:0]  sub_y = 8'h00;
    logic        sub_fail, sub_finish;
    logic [15:0] sub_err;
    logic [1:0]  sub_st;

    logic [15:0] long_a, long_b, long_y;
    logic        long_fail, long_finish;
    logic [15:0] long_err;
    logic [1:0]  long_st;
    int          long_cyc = 0;

    assign add_y  = add_a + add_b;
    assign long_y = long_a * long_b + 16'd1;

    // Two-stage registered adders standing in for pipelined DUTs
    always_ff @(posedge clock) begin
        l2_p1 <= l2_a + l2_b;
        l2_p2 <= l2_p1;
        l1_p1 <= l1_a + l1_b;
        l1_p2 <= l1_p1;
    end

    // Cycle number of the long run (cycle 0 = first cycle with reset_long low)
    always_ff @(posedge clock) begin
        if (reset_long) long_cyc <= 0;
        else            long_cyc <= long_cyc + 1;
    end

    test_vec_binop #(.WIDTH(8), .OP(OP_ADD), .LATENCY(0), .NUM_VECTORS(16)) u_add (
        .clock(clock), .reset(reset), .dut_a(add_a), .dut_b(add_b), .dut_y(add_y),
        .fail(add_fail), .finish(add_finish), .err_count(add_err), .dbg_state(add_st));

    test_vec_binop #(.WIDTH(8), .OP(OP_ADD), .LATENCY(0), .NUM_VECTORS(16)) u_stuck (
        .clock(clock), .reset(reset), .dut_a(stuck_a), .dut_b(stuck_b), .dut_y(8'h00),
        .fail(stuck_fail), .finish(stuck_finish), .err_count(stuck_err), .dbg_state(stuck_st));

    test_vec_binop #(.WIDTH(8), .OP(OP_ADD), .LATENCY(2), .NUM_VECTORS(16)) u_l2 (
        .clock(clock), .reset(reset), .dut_a(l2_a), .dut_b(l2_b), .dut_y(l2_p2),
        .fail(l2_fail), .finish(l2_finish), .err_count(l2_err), .dbg_state(l2_st));

    test_vec_binop #(.WIDTH(8), .OP(OP_ADD), .LATENCY(1), .NUM_VECTORS(16)) u_l1 (
        .clock(clock), .reset(reset), .dut_a(l1_a), .dut_b(l1_b), .dut_y(l1_p2),
        .fail(l1_fail), .finish(l1_finish), .err_count(l1_err), .dbg_state(l1_st));

    test_vec_binop #(.WIDTH(8), .OP(OP_SUB), .LATENCY(0), .NUM_VECTORS(16)) u_sub (
        .clock(clock), .reset(reset), .dut_a(sub_a), .dut_b(sub_b), .dut_y(sub_y),
        .fail(sub_fail), .finish(sub_finish), .err_count(sub_err), .dbg_state(sub_st));

    test_vec_binop #(.WIDTH(16), .OP(OP_MUL), .LATENCY(0), .NUM_VECTORS(65535)) u_long (
        .clock(clock), .reset(reset_long), .dut_a(long_a), .dut_b(long_b), .dut_y(long_y),
        .fail(long_fail), .finish(long_finish), .err_count(long_err), .dbg_state(long_st));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next cycle and settle just past the active edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_vec(input int k);
        check($sformatf("add_a[%0d]", k), 32'(add_a), 32'(tbl[k].a));
        check($sformatf("add_b[%0d]", k), 32'(add_b), 32'(tbl[k].b));
    endtask

    int exp_stuck_err;
    int first_bad;

    initial begin
        tbl[0]  = '{8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{8'hFF, 8'h01, 8'h00, 8'hFE};
        tbl[2]  = '{8'h5A, 8'h3C, 8'h96, 8'h1E};
        tbl[3]  = '{8'h2D, 8'h1E, 8'h4B, 8'h0F};
        tbl[4]  = '{8'hAE, 8'h0F, 8'hBD, 8'h9F};
        tbl[5]  = '{8'h57, 8'hBF, 8'h16, 8'h98};
        tbl[6]  = '{8'h93, 8'hE7, 8'h7A, 8'hAC};
        tbl[7]  = '{8'hF1, 8'hCB, 8'hBC, 8'h26};
        tbl[8]  = '{8'hC0, 8'hDD, 8'h9D, 8'hE3};
        tbl[9]  = '{8'h60, 8'hD6, 8'h36, 8'h8A};
        tbl[10] = '{8'h30, 8'h6B, 8'h9B, 8'hC5};
        tbl[11] = '{8'h18, 8'h8D, 8'hA5, 8'h8B};
        tbl[12] = '{8'h0C, 8'hFE, 8'h0A, 8'h0E};
        tbl[13] = '{8'h06, 8'h7F, 8'h85, 8'h87};
        tbl[14] = '{8'h03, 8'h87, 8'h8A, 8'h7C};
        tbl[15] = '{8'hB9, 8'hFB, 8'hB4, 8'hBE};

        // A stuck-at-zero result matches every vector whose sum wraps to 0
        // (vectors 0 and 1 here), so count the real mismatches from the table.
        exp_stuck_err = 0;
        first_bad     = -1;
        for (int k = 0; k < 16; k++) begin
            if (tbl[k].y_add != 8'h00) begin
                exp_stuck_err++;
                if (first_bad < 0) first_bad = k;
            end
        end

        // ---------------- reset values ----------------
        repeat (3) tick();
        check("rst_add_a",      32'(add_a),      32'd0);
        check("rst_add_b",      32'(add_b),      32'd0);
        check("rst_add_fail",   32'(add_fail),   32'd0);
        check("rst_add_finish", 32'(add_finish), 32'd0);
        check("rst_add_err",    32'(add_err),    32'd0);
        check("rst_add_state",  32'(add_st),     32'(ST_RUN));

        // ---------------- run 1 ----------------
        reset      = 1'b0;
        reset_long = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            if (k < 16) begin
                sub_y = tbl[k].y_sub;
                check_vec(k);
            end else begin
                sub_y = 8'h00;
                check($sformatf("drain_a[%0d]", k), 32'(add_a), 32'd0);
                check($sformatf("drain_b[%0d]", k), 32'(add_b), 32'd0);
            end
            check($sformatf("add_finish[%0d]", k),  32'(add_finish), 32'(k >= 16));
            check($sformatf("l2_finish[%0d]", k),   32'(l2_finish),  32'(k >= 18));
            check($sformatf("l2_a[%0d]", k),        32'(l2_a),       32'(k < 16 ? tbl[k % 16].a : 8'h00));
            check($sformatf("stuck_fail[%0d]", k),  32'(stuck_fail), 32'(k > first_bad));
            tick();
        end
        check("add_fail",   32'(add_fail),   32'd0);
        check("add_err",    32'(add_err),    32'd0);
        check("add_state",  32'(add_st),     32'(ST_DONE));
        check("stuck_err",  32'(stuck_err),  32'(exp_stuck_err));
        check("stuck_fin",  32'(stuck_finish), 32'd1);
        check("l2_fail",    32'(l2_fail),    32'd0);
        check("l2_err",     32'(l2_err),     32'd0);
        check("l1_fail",    32'(l1_fail),    32'd1);
        check("sub_fail",   32'(sub_fail),   32'd0);
        check("sub_err",    32'(sub_err),    32'd0);
        check("sub_finish", 32'(sub_finish), 32'd1);

        // ---------------- run 2: aborted by reset in cycle 5 ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sub_y = tbl[k].y_sub;
            check_vec(k);
            tick();
        end
        check("stuck_fail_pre_rst", 32'(stuck_fail), 32'd1);
        sub_y = tbl[5].y_sub;
        reset = 1'b1;
        tick();
        check("mid_rst_a",          32'(add_a),      32'd0);
        check("mid_rst_b",          32'(add_b),      32'd0);
        check("mid_rst_stuck_fail", 32'(stuck_fail), 32'd0);
        check("mid_rst_stuck_err",  32'(stuck_err),  32'd0);
        check("mid_rst_finish",     32'(add_finish), 32'd0);
        check("mid_rst_state",      32'(add_st),     32'(ST_RUN));

        // ---------------- run 3: identical sequence, bad final result ----------------
        reset = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) begin
                sub_y = (k == 15) ? ~tbl[k].y_sub : tbl[k].y_sub;
                check_vec(k);
                check($sformatf("sub_a[%0d]", k), 32'(sub_a), 32'(tbl[k].a));
            end else begin
                sub_y = 8'h00;
            end
            if (k == 15) check("sub_fail_before_last", 32'(sub_fail), 32'd0);
            if (k == 16) begin
                check("sub_fail_at_finish", 32'(sub_fail),   32'd1);
                check("sub_finish_rise",    32'(sub_finish), 32'd1);
            end
            tick();
        end
        check("sub_err_last", 32'(sub_err), 32'd1);
        check("add_pass_run3", 32'(add_fail), 32'd0);

        // ---------------- long run: every vector mismatches ----------------
        while (long_finish !== 1'b1 && long_cyc < 70000) tick();
        check("long_finish_cycle", 32'(long_cyc),  32'd65535);
        check("long_err",          32'(long_err),  32'h0000_FFFF);
        check("long_fail",         32'(long_fail), 32'd1);
        check("long_state",        32'(long_st),   32'(ST_DONE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
